ppu_oam_dma: RTL and testbench

Sprite DMA engine for CPU register $4014. A CPU write of page number N to $4014 halts the CPU and copies 256 bytes from CPU address $NN00–$NNFF into OAM. The copy runs as alternating bus read / $2004 write cycles, so the PPU register block's OAMDATA path performs every OAM store, and OAMADDR auto-increments as a side effect. The engine sits between the CPU core and the system bus mux: it watches CPU writes, asserts halt, and takes over the bus while active.

---
 rtl/ppu_oam_dma_if.sv | 24 ++
 rtl/ppu_oam_dma.sv | 99 +++++++++
 tb/tb_ppu_oam_dma.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ppu_oam_dma_if.sv
// Bus bundle between the CPU core, the sprite DMA engine and the system bus mux.
// The master modport is the DMA engine's view.
interface ppu_oam_dma_if;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic [7:0]  dma_rdata;
  logic        cpu_halt;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_wn;
  logic [7:0]  dma_wdata;
  logic        dma_done;

  modport master (
    input  bus_addr, bus_wn, bus_wdata, dma_rdata,
    output cpu_halt, dma_active, dma_addr, dma_wn, dma_wdata, dma_done
  );

  modport slave (
    output bus_addr, bus_wn, bus_wdata, dma_rdata,
    input  cpu_halt, dma_active, dma_addr, dma_wn, dma_wdata, dma_done
  );
endinterface

// File: rtl/ppu_oam_dma.sv
// Sprite DMA engine: a CPU write to $4014 halts the CPU and copies page $NN00-$NNFF into OAM
// through alternating bus-read / OAMDATA-write cycles.
module ppu_oam_dma #(
  parameter logic [15:0] P_DMA_REG = 16'h4014,
  parameter logic [15:0] P_OAMDATA = 16'h2004
) (
  input logic           i_cpu_clk,
  input logic           i_cpu_rstn,
  ppu_oam_dma_if.master bus
);

  typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite} state_e;

  state_e     state_q, state_d;
  logic       odd_q;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       trigger;

  // Writes to the trigger register outside IDLE are ignored, so no restart path exists.
  assign trigger = (state_q == StIdle) && (bus.bus_addr == P_DMA_REG) && !bus.bus_wn;

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      state_q <= StIdle;
      odd_q   <= 1'b0;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      odd_q   <= ~odd_q;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          page_d  = bus.bus_wdata;
          idx_d   = 8'h00;
          state_d = StHalt;
        end
      end
      // An odd HALT cycle means the following cycle is even, so READ can start directly.
      StHalt:  state_d = odd_q ? StRead : StAlign;
      StAlign: state_d = StRead;
      StRead: begin
        data_d  = bus.dma_rdata;
        state_d = StWrite;
      end
      StWrite: begin
        if (idx_q == 8'hFF) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cpu_halt   = (state_q != StIdle);
    bus.dma_active = 1'b0;
    bus.dma_addr   = 16'h0000;
    bus.dma_wn     = 1'b1;
    bus.dma_wdata  = 8'h00;
    bus.dma_done   = done_q;
    unique case (state_q)
      StRead: begin
        bus.dma_active = 1'b1;
        bus.dma_addr   = {page_q, idx_q};
      end
      StWrite: begin
        bus.dma_active = 1'b1;
        bus.dma_addr   = P_OAMDATA;
        bus.dma_wn     = 1'b0;
        bus.dma_wdata  = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Bench for ppu_oam_dma: system bus mux, CPU memory and a minimal OAMADDR/OAMDATA model,
// with expected bus traces built per transfer from the transfer rules.
module tb_ppu_oam_dma;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ppu_oam_dma_if bus ();

  ppu_oam_dma #(
    .P_DMA_REG(16'h4014),
    .P_OAMDATA(16'h2004)
  ) dut (
    .i_cpu_clk (clk),
    .i_cpu_rstn(rstn),
    .bus       (bus)
  );

  logic [7:0]  mem [65536];
  logic [7:0]  oam [256];
  logic [7:0]  oamaddr = 8'h00;
  int          stores  = 0;
  int          ncyc    = 0;
  int          nvec    = 0;
  int          nmis    = 0;
  logic [15:0] eff_addr;
  logic        eff_wn;
  logic [7:0]  eff_wdata;
  logic [27:0] dut_outs;

  always_comb begin
    eff_addr  = bus.dma_active ? bus.dma_addr  : bus.bus_addr;
    eff_wn    = bus.dma_active ? bus.dma_wn    : bus.bus_wn;
    eff_wdata = bus.dma_active ? bus.dma_wdata : bus.bus_wdata;
  end

  assign bus.dma_rdata = mem[eff_addr];
  assign dut_outs = {bus.cpu_halt, bus.dma_active, bus.dma_addr, bus.dma_wn, bus.dma_wdata,
                     bus.dma_done};

  always @(posedge clk) begin
    if (!eff_wn) begin
      if (eff_addr == 16'h2003) begin
        oamaddr <= eff_wdata;
      end else if (eff_addr == 16'h2004) begin
        oam[oamaddr] <= eff_wdata;
        oamaddr      <= oamaddr + 8'h01;
        stores       <= stores + 1;
      end
    end
  end

  // Cycles since reset release; its parity equals the DUT's free-running parity bit.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  function automatic logic [27:0] tup(input logic h, input logic a, input logic [15:0] ad,
                                      input logic wn, input logic [7:0] wd, input logic dn);
    return {h, a, ad, wn, wd, dn};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic wn, input logic [7:0] d);
    bus.bus_addr  = a;
    bus.bus_wn    = wn;
    bus.bus_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // align_req: 0 = trigger on even cycle (no ALIGN), 1 = odd (ALIGN), 2 = random.
  // abort_pair >= 0 pulls reset during the READ of that pair.
  task automatic run_xfer(input logic [7:0] page, input logic [7:0] start, input int align_req,
                          input bit retrig, input int abort_pair, output int halt_len,
                          output logic [15:0] first_addr, output int align);
    logic [27:0] expq[$];
    logic [7:0]  old_oam [256];
    logic [7:0]  exp_oam [256];
    logic [7:0]  b;
    logic [27:0] idle_t;
    int          s0;
    bit          seen;
    idle_t = tup(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0);
    drive(16'h2003, 1'b0, start);
    tick();
    drive(16'h0000, 1'b1, 8'h00);
    repeat ($urandom_range(0, 3)) tick();
    if (align_req != 2) while ((ncyc % 2) != align_req) tick();
    // HALT sees the opposite parity of the trigger cycle; ALIGN is needed when HALT is even.
    align = ncyc % 2;
    expq.push_back(idle_t);
    expq.push_back(tup(1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
    if (align == 1) expq.push_back(tup(1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      expq.push_back(tup(1'b1, 1'b1, {page, b}, 1'b1, 8'h00, 1'b0));
      expq.push_back(tup(1'b1, 1'b1, 16'h2004, 1'b0, mem[{page, b}], 1'b0));
    end
    expq.push_back(tup(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b1));
    expq.push_back(idle_t);
    old_oam = oam;
    exp_oam = oam;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      exp_oam[8'(start + b)] = mem[{page, b}];
    end
    s0 = stores;
    halt_len = 0;
    first_addr = 16'hxxxx;
    seen = 1'b0;
    for (int k = 0; k < expq.size(); k++) begin
      if (k == 0) drive(16'h4014, 1'b0, page);
      else if (retrig && k == 2 + align + 2 * 50) drive(16'h4014, 1'b0, 8'h07);
      else drive(16'h0000, 1'b1, 8'h00);
      if (abort_pair >= 0 && k == 2 + align + 2 * abort_pair) begin
        drive(16'h0000, 1'b1, 8'h00);
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", dut_outs, idle_t);
        tick();
        check("held_reset_outputs", dut_outs, idle_t);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("post_reset_outputs", dut_outs, idle_t);
        check("abort_store_count", stores - s0, abort_pair);
        for (int i = 0; i < 256; i++) begin
          b = 8'(i);
          check("abort_oam", oam[8'(start + b)],
                (i < abort_pair) ? exp_oam[8'(start + b)] : old_oam[8'(start + b)]);
        end
        return;
      end
      @(negedge clk);
      check($sformatf("cycle_%0d", k), dut_outs, expq[k]);
      if (bus.cpu_halt) halt_len++;
      if (bus.dma_active && !seen) begin
        first_addr = bus.dma_addr;
        seen = 1'b1;
      end
      tick();
    end
    for (int i = 0; i < 256; i++) check("oam_byte", oam[i], exp_oam[i]);
    check("oamaddr_after", oamaddr, start);
    check("store_count", stores - s0, 256);
  endtask

  typedef struct {
    logic [7:0]  page;
    logic [7:0]  start;
    int          align;
    bit          retrig;
    int          exp_len;
    logic [15:0] exp_first;
  } vec_t;

  vec_t        vecs [6];
  int          hl;
  int          al;
  logic [15:0] fa;
  logic [7:0]  pg;

  initial begin
    vecs[0] = '{8'h02, 8'h00, 0, 1'b0, 513, 16'h0200};
    vecs[1] = '{8'h05, 8'h00, 1, 1'b0, 514, 16'h0500};
    vecs[2] = '{8'h03, 8'h10, 0, 1'b0, 513, 16'h0300};
    vecs[3] = '{8'h20, 8'hFF, 1, 1'b0, 514, 16'h2000};
    vecs[4] = '{8'hFF, 8'h80, 0, 1'b0, 513, 16'hFF00};
    vecs[5] = '{8'h01, 8'h33, 1, 1'b1, 514, 16'h0100};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0300 + 16'(i)] = 8'(i) ^ 8'hA5;

    drive(16'h0000, 1'b1, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", dut_outs, tup(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
    rstn = 1'b1;
    tick();

    foreach (vecs[v]) begin
      run_xfer(vecs[v].page, vecs[v].start, vecs[v].align, vecs[v].retrig, -1, hl, fa, al);
      check($sformatf("halt_len_v%0d", v), hl, vecs[v].exp_len);
      check($sformatf("first_read_v%0d", v), fa, vecs[v].exp_first);
      if (v == 2) begin
        for (int i = 0; i < 256; i++) check("datapath_a5", oam[8'(i + 16)], 8'(i) ^ 8'hA5);
      end
    end

    for (int r = 0; r < 4; r++) begin
      pg = 8'($urandom);
      run_xfer(pg, 8'($urandom), 2, 1'($urandom), -1, hl, fa, al);
      check("rand_halt_len", hl, 513 + al);
      check("rand_first_read", fa, {pg, 8'h00});
    end

    run_xfer(8'h04, 8'h20, 2, 1'b0, 100, hl, fa, al);
    run_xfer(8'h0A, 8'h00, 0, 1'b0, -1, hl, fa, al);
    check("after_abort_halt_len", hl, 513);
    check("after_abort_first_read", fa, 16'h0A00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
